// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: sends the ALU result byte as UART 8N1 text "HL\r"
// (two upper-case hex digits, then CR). A frame is started by a synchronised
// rising edge of the send button, or automatically when the result differs
// from the last value sent.
//
// state | meaning
// IDLE  | line idle high, waiting for a request or auto trigger
// START | start bit (tx=0) of the current character
// DATA  | data bits of the current character, LSB first
// STOP  | stop bit (tx=1); then next character or back to IDLE
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit AUTO_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] result,
  input  logic       send,
  input  logic       auto_en,
  output logic       tx,
  output logic       tx_oe,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_nxt;
  logic        sync1, sync2, prev;
  logic        auto_q;
  logic        tx_nxt, busy_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [1:0]  char_idx, char_nxt;
  logic [7:0]  snap, snap_nxt;
  logic [7:0]  last_sent, last_nxt;
  logic [7:0]  cur_char;
  logic [2:0]  next_bit;
  logic        req;
  logic        bit_done;
  logic        trigger;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign tx_oe    = 1'b1;
  assign req      = sync2 & ~prev;
  assign bit_done = (cnt == LAST_CNT);
  assign trigger  = ena & (req | (auto_q & (result != last_sent)));
  assign next_bit = bit_idx + 3'd1;

  // character currently being shifted out, selected by char_idx
  always_comb begin
    cur_char = 8'h0D;
    case (char_idx)
      2'd0:    cur_char = hex_char(snap[7:4]);
      2'd1:    cur_char = hex_char(snap[3:0]);
      default: cur_char = 8'h0D;
    endcase
  end

  // state register, button synchroniser and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      auto_q    <= AUTO_DEFAULT;
      tx        <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      char_idx  <= '0;
      snap      <= '0;
      last_sent <= '0;
    end else begin
      state     <= state_nxt;
      sync1     <= send;
      sync2     <= sync1;
      prev      <= sync2;
      auto_q    <= auto_en;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      char_idx  <= char_nxt;
      snap      <= snap_nxt;
      last_sent <= last_nxt;
    end
  end

  // next-state and next registered outputs; tx is computed one edge early
  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    char_nxt  = char_idx;
    snap_nxt  = snap;
    last_nxt  = last_sent;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        cnt_nxt  = '0;
        if (trigger) begin
          snap_nxt  = result;
          last_nxt  = result;
          char_nxt  = 2'd0;
          state_nxt = START;
          busy_nxt  = 1'b1;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_nxt   = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
          tx_nxt    = cur_char[0];
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = next_bit;
            tx_nxt  = cur_char[next_bit];
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_nxt = '0;
          if (char_idx < 2'd2) begin
            char_nxt  = char_idx + 2'd1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            tx_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
